// File: rtl/stb_seq_ctrl.sv
// -----------------------------------------------------------------------------
// stb_seq_ctrl
//
// Sequencer for an external strobe generator. A start request resets the
// generator, waits for it to report ready (with an optional timeout), checks
// the measured period against an inclusive window, and then enables the
// output while counting a burst of strobes. Errors park the block in FAULT
// with a code until the next start or abort.
//
// Optional feature (macro STB_SEQ_PERIOD_TRACK_EN): when defined, the period
// is re-checked on every strobe edge during RUN and period_o follows it.
// When the macro is undefined, the period is checked once in CHECK and
// period_o holds during RUN.
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           synchronous active-high reset
//   start_i         begin a sequence (honoured in IDLE and FAULT only)
//   abort_i         return to IDLE from any state; wins over all other inputs
//   burst_len_i     strobes per burst, 0 = continuous
//   timeout_i       WAIT_RDY cycle limit, 0 = no limit
//   period_min_i    lower bound of the accepted period (inclusive)
//   period_max_i    upper bound of the accepted period (inclusive)
//   gen_rdy_i       generator ready
//   gen_err_i       generator error
//   gen_stb_i       generator strobe (rising edges are counted)
//   gen_period_i    period measured by the generator
//   gen_rst_o       generator reset
//   run_det_o       detection enable
//   oe_o            output enable
//   busy_o          high outside IDLE and FAULT
//   done_o          one-cycle pulse at burst completion
//   err_o           high in FAULT
//   err_code_o      1 timeout, 2 period out of window, 3 generator error
//   period_o        accepted period
//   stb_cnt_o       strobes counted in the current burst
// -----------------------------------------------------------------------------
module stb_seq_ctrl #(
   parameter int unsigned T_CNT_WIDTH    = 32,
   parameter int unsigned BURST_WIDTH    = 16,
   parameter int unsigned GEN_RST_CYCLES = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [BURST_WIDTH-1:0] burst_len_i,
   input  logic [T_CNT_WIDTH-1:0] timeout_i,
   input  logic [T_CNT_WIDTH-1:0] period_min_i,
   input  logic [T_CNT_WIDTH-1:0] period_max_i,
   input  logic                   gen_rdy_i,
   input  logic                   gen_err_i,
   input  logic                   gen_stb_i,
   input  logic [T_CNT_WIDTH-1:0] gen_period_i,
   output logic                   gen_rst_o,
   output logic                   run_det_o,
   output logic                   oe_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [1:0]             err_code_o,
   output logic [T_CNT_WIDTH-1:0] period_o,
   output logic [BURST_WIDTH-1:0] stb_cnt_o
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GEN_RST  = 3'd1,
      ST_WAIT_RDY = 3'd2,
      ST_CHECK    = 3'd3,
      ST_RUN      = 3'd4,
      ST_DONE     = 3'd5,
      ST_FAULT    = 3'd6
   } state_t;

   localparam logic [7:0] RST_LAST = 8'(GEN_RST_CYCLES - 1);

   state_t                 state_q, state_d;
   logic [7:0]             rst_cnt_q, rst_cnt_d;
   logic [T_CNT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [BURST_WIDTH-1:0] burst_q, burst_d;
   logic [T_CNT_WIDTH-1:0] tmo_q, tmo_d;
   logic [T_CNT_WIDTH-1:0] pmin_q, pmin_d;
   logic [T_CNT_WIDTH-1:0] pmax_q, pmax_d;
   logic                   stb_prev_q;

   logic                   gen_rst_q, gen_rst_d;
   logic                   run_det_q, run_det_d;
   logic                   oe_q, oe_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic [1:0]             err_code_q, err_code_d;
   logic [T_CNT_WIDTH-1:0] period_q, period_d;
   logic [BURST_WIDTH-1:0] stb_cnt_q, stb_cnt_d;

   logic                   stb_edge;
   logic [BURST_WIDTH-1:0] stb_cnt_inc;

   // An inverted window (lo > hi) can never contain a value, so it always fails.
   function automatic logic in_window(input logic [T_CNT_WIDTH-1:0] p,
                                      input logic [T_CNT_WIDTH-1:0] lo,
                                      input logic [T_CNT_WIDTH-1:0] hi);
      return (p >= lo) && (p <= hi);
   endfunction

   assign stb_edge    = gen_stb_i & ~stb_prev_q;
   assign stb_cnt_inc = stb_cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      burst_d    = burst_q;
      tmo_d      = tmo_q;
      pmin_d     = pmin_q;
      pmax_d     = pmax_q;
      err_code_d = err_code_q;
      period_d   = period_q;
      stb_cnt_d  = stb_cnt_q;

      if (abort_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_FAULT: begin
               if (start_i) begin
                  burst_d   = burst_len_i;
                  tmo_d     = timeout_i;
                  pmin_d    = period_min_i;
                  pmax_d    = period_max_i;
                  stb_cnt_d = '0;
                  rst_cnt_d = '0;
                  state_d   = ST_GEN_RST;
               end
            end
            ST_GEN_RST: begin
               if (rst_cnt_q == RST_LAST) begin
                  // Counter value 1 stands for the first WAIT_RDY cycle.
                  tmo_cnt_d = T_CNT_WIDTH'(1);
                  state_d   = ST_WAIT_RDY;
               end else begin
                  rst_cnt_d = rst_cnt_q + 8'd1;
               end
            end
            ST_WAIT_RDY: begin
               if (gen_err_i) begin
                  state_d    = ST_FAULT;
                  err_code_d = 2'd3;
               end else if (gen_rdy_i) begin
                  state_d = ST_CHECK;
               end else if ((tmo_q != '0) && (tmo_cnt_q == tmo_q)) begin
                  state_d    = ST_FAULT;
                  err_code_d = 2'd1;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + 1'b1;
               end
            end
            ST_CHECK: begin
               period_d = gen_period_i;
               if (in_window(gen_period_i, pmin_q, pmax_q)) begin
                  state_d = ST_RUN;
               end else begin
                  state_d    = ST_FAULT;
                  err_code_d = 2'd2;
               end
            end
            ST_RUN: begin
               if (gen_err_i) begin
                  state_d    = ST_FAULT;
                  err_code_d = 2'd3;
               end else if (stb_edge) begin
`ifdef STB_SEQ_PERIOD_TRACK_EN
                  period_d = gen_period_i;
                  if (!in_window(gen_period_i, pmin_q, pmax_q)) begin
                     state_d    = ST_FAULT;
                     err_code_d = 2'd2;
                  end else
`endif
                  begin
                     // Burst length 0 never matches, so the count free-runs and wraps.
                     stb_cnt_d = stb_cnt_inc;
                     if ((burst_q != '0) && (stb_cnt_inc == burst_q)) begin
                        state_d = ST_DONE;
                     end
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Leaving FAULT (by start or abort) clears the code.
      if (state_d != ST_FAULT) begin
         err_code_d = 2'd0;
      end

      // Outputs are decoded from the next state so they line up with it.
      gen_rst_d = (state_d == ST_GEN_RST);
      run_det_d = (state_d == ST_WAIT_RDY) || (state_d == ST_RUN);
      oe_d      = (state_d == ST_RUN);
      busy_d    = (state_d != ST_IDLE) && (state_d != ST_FAULT);
      done_d    = (state_d == ST_DONE);
      err_d     = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         stb_prev_q <= 1'b0;
         gen_rst_q  <= 1'b0;
         run_det_q  <= 1'b0;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
         period_q   <= '0;
         stb_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         stb_prev_q <= gen_stb_i;
         gen_rst_q  <= gen_rst_d;
         run_det_q  <= run_det_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         period_q   <= period_d;
         stb_cnt_q  <= stb_cnt_d;
      end
      // Working counters and latched settings are always rewritten before use.
      rst_cnt_q <= rst_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      burst_q   <= burst_d;
      tmo_q     <= tmo_d;
      pmin_q    <= pmin_d;
      pmax_q    <= pmax_d;
   end

   assign gen_rst_o  = gen_rst_q;
   assign run_det_o  = run_det_q;
   assign oe_o       = oe_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign err_code_o = err_code_q;
   assign period_o   = period_q;
   assign stb_cnt_o  = stb_cnt_q;

endmodule

// File: tb/tb_stb_seq_ctrl.sv
// Bench for stb_seq_ctrl. Completion and fault events are checked by a
// scoreboard monitor; cycle-level behaviour is checked inline. A 12-bit
// strobe counter keeps the wrap scenario short (4400 strobes wrap to 304).
module tb_stb_seq_ctrl;

   localparam int TW  = 32;
   localparam int BW  = 12;
   localparam int GRC = 4;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic [BW-1:0] burst_len_i = '0;
   logic [TW-1:0] timeout_i = '0;
   logic [TW-1:0] period_min_i = '0;
   logic [TW-1:0] period_max_i = '0;
   logic          gen_rdy_i = 1'b0;
   logic          gen_err_i = 1'b0;
   logic          gen_stb_i = 1'b0;
   logic [TW-1:0] gen_period_i = '0;
   logic          gen_rst_o, run_det_o, oe_o, busy_o, done_o, err_o;
   logic [1:0]    err_code_o;
   logic [TW-1:0] period_o;
   logic [BW-1:0] stb_cnt_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit            is_err;
      logic [1:0]    code;
      logic [TW-1:0] period;
      logic [BW-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t ev;
   bit   err_prev = 1'b0;

   stb_seq_ctrl #(
      .T_CNT_WIDTH(TW),
      .BURST_WIDTH(BW),
      .GEN_RST_CYCLES(GRC)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .start_i(start_i),
      .abort_i(abort_i),
      .burst_len_i(burst_len_i),
      .timeout_i(timeout_i),
      .period_min_i(period_min_i),
      .period_max_i(period_max_i),
      .gen_rdy_i(gen_rdy_i),
      .gen_err_i(gen_err_i),
      .gen_stb_i(gen_stb_i),
      .gen_period_i(gen_period_i),
      .gen_rst_o(gen_rst_o),
      .run_det_o(run_det_o),
      .oe_o(oe_o),
      .busy_o(busy_o),
      .done_o(done_o),
      .err_o(err_o),
      .err_code_o(err_code_o),
      .period_o(period_o),
      .stb_cnt_o(stb_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe();
      gen_stb_i = 1'b1;
      tick();
      gen_stb_i = 1'b0;
      tick();
   endtask

   task automatic push(input bit is_err, input logic [1:0] code,
                       input logic [TW-1:0] per, input logic [BW-1:0] cnt);
      exp_t e;
      e.is_err = is_err;
      e.code   = code;
      e.period = per;
      e.cnt    = cnt;
      sb.push_back(e);
   endtask

   // Start, pass through GEN_RST, raise ready on the first WAIT_RDY cycle,
   // and stop on the cycle after CHECK (RUN or FAULT).
   task automatic run_start(input logic [BW-1:0] b, input logic [TW-1:0] tmo,
                            input logic [TW-1:0] lo, input logic [TW-1:0] hi,
                            input logic [TW-1:0] per);
      burst_len_i  = b;
      timeout_i    = tmo;
      period_min_i = lo;
      period_max_i = hi;
      gen_period_i = per;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (GRC) tick();
      gen_rdy_i = 1'b1;
      tick();
      gen_rdy_i = 1'b0;
      tick();
   endtask

   task automatic do_abort();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      tick();
   endtask

   // Scoreboard monitor: a done pulse or a rising err_o is one event.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_i && (done_o || (err_o && !err_prev))) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: done=%0b err=%0b code=%0d with nothing expected",
                        done_o, err_o, err_code_o);
            end else begin
               ev = sb.pop_front();
               chk("ev_is_err", 64'(err_o), 64'(ev.is_err));
               chk("ev_code", 64'(err_code_o), 64'(ev.code));
               chk("ev_period", 64'(period_o), 64'(ev.period));
               chk("ev_stb_cnt", 64'(stb_cnt_o), 64'(ev.cnt));
            end
         end
         err_prev = err_o;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // Reset state
      rst_i = 1'b1;
      tick();
      tick();
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_err", 64'(err_o), 64'(0));
      chk("rst_gen_rst", 64'(gen_rst_o), 64'(0));
      chk("rst_period", 64'(period_o), 64'(0));
      rst_i = 1'b0;
      tick();

      // Nominal burst of 3 with ready 10 cycles into WAIT_RDY
      push(1'b0, 2'd0, 100, 3);
      burst_len_i  = 3;
      timeout_i    = 0;
      period_min_i = 90;
      period_max_i = 110;
      gen_period_i = 100;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      n = 0;
      while (gen_rst_o && n < 20) begin
         n++;
         tick();
      end
      chk("gen_rst_cycles", 64'(n), 64'(4));
      chk("wait_run_det", 64'(run_det_o), 64'(1));
      repeat (9) tick();
      chk("wait_busy_no_tmo", 64'(busy_o), 64'(1));
      gen_rdy_i = 1'b1;
      tick();
      gen_rdy_i = 1'b0;
      tick();
      chk("run_oe", 64'(oe_o), 64'(1));
      chk("run_period", 64'(period_o), 64'(100));
      repeat (3) strobe();
      chk("done_busy_after", 64'(busy_o), 64'(0));
      chk("done_cnt_after", 64'(stb_cnt_o), 64'(3));
      chk("done_oe_after", 64'(oe_o), 64'(0));

      // Timeout of 8 with ready never asserted
      push(1'b1, 2'd1, 100, 0);
      timeout_i = 8;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (11) tick();
      chk("tmo_not_yet", 64'(err_o), 64'(0));
      tick();
      chk("tmo_err", 64'(err_o), 64'(1));
      chk("tmo_code", 64'(err_code_o), 64'(1));
      chk("tmo_busy", 64'(busy_o), 64'(0));
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("restart_err_clr", 64'(err_o), 64'(0));
      chk("restart_gen_rst", 64'(gen_rst_o), 64'(1));
      do_abort();
      chk("abort_idle_busy", 64'(busy_o), 64'(0));

      // Period out of window, then inverted window
      push(1'b1, 2'd2, 120, 0);
      run_start(3, 0, 90, 110, 120);
      chk("win_err", 64'(err_o), 64'(1));
      chk("win_period", 64'(period_o), 64'(120));
      push(1'b1, 2'd2, 100, 0);
      run_start(3, 0, 110, 90, 100);
      chk("inv_code", 64'(err_code_o), 64'(2));
      do_abort();
      chk("abort_clr_code", 64'(err_code_o), 64'(0));

      // Generator error coinciding with timeout on the first WAIT_RDY cycle
      push(1'b1, 2'd3, 100, 0);
      timeout_i = 1;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (GRC) tick();
      gen_err_i = 1'b1;
      tick();
      gen_err_i = 1'b0;
      chk("prio_code", 64'(err_code_o), 64'(3));
      do_abort();

      // Abort on the second strobe edge of a burst of 5
      run_start(5, 0, 90, 110, 100);
      strobe();
      gen_stb_i = 1'b1;
      abort_i   = 1'b1;
      tick();
      gen_stb_i = 1'b0;
      abort_i   = 1'b0;
      chk("abort_oe", 64'(oe_o), 64'(0));
      chk("abort_busy", 64'(busy_o), 64'(0));
      chk("abort_cnt", 64'(stb_cnt_o), 64'(1));
      tick();

      // Abort wins over start in IDLE
      start_i = 1'b1;
      abort_i = 1'b1;
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      chk("abort_vs_start", 64'(busy_o), 64'(0));

      // Continuous burst wraps the 12-bit counter, then reset mid-run
      run_start(0, 0, 90, 110, 100);
      repeat (4400) strobe();
      chk("wrap_cnt", 64'(stb_cnt_o), 64'(304));
      chk("wrap_oe", 64'(oe_o), 64'(1));
      rst_i = 1'b1;
      tick();
      chk("midrst_oe", 64'(oe_o), 64'(0));
      chk("midrst_busy", 64'(busy_o), 64'(0));
      chk("midrst_run_det", 64'(run_det_o), 64'(0));
      chk("midrst_cnt", 64'(stb_cnt_o), 64'(0));
      chk("midrst_period", 64'(period_o), 64'(0));
      rst_i = 1'b0;
      tick();

      // Period drifts to 115 after the first strobe of a burst of 4
`ifdef STB_SEQ_PERIOD_TRACK_EN
      push(1'b1, 2'd2, 115, 1);
`else
      push(1'b0, 2'd0, 100, 4);
`endif
      run_start(4, 0, 90, 110, 100);
      strobe();
      gen_period_i = 115;
      repeat (3) strobe();
`ifdef STB_SEQ_PERIOD_TRACK_EN
      chk("drift_code", 64'(err_code_o), 64'(2));
`else
      chk("drift_period", 64'(period_o), 64'(100));
`endif
      do_abort();

      tick();
      chk("sb_drained", 64'(sb.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
